// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the debug register-dump path: dump FSM states,
// byte width, default sync byte and a counter-width helper.
package reg_dump_reader_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_FETCH  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SEND   = 3'd4,
        ST_DONE   = 3'd5
    } dump_state_t;

    // Width of a counter over the bytes of a data_w-bit word (at least 1 bit).
    function automatic int byte_cnt_w(input int data_w);
        int nbytes;
        nbytes = data_w / BYTE_W;
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-bank read port plus valid/ready byte stream towards the debug UART.
interface reg_dump_reader_if
    import reg_dump_reader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rd_addr,
        input  rd_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/reg_dump_reader_word_byte_serializer.sv
// Splits a loaded word into bytes, most significant byte first.
module word_byte_serializer
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic [BYTE_W-1:0] byte_out,
    output logic              last
);
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int CNT_W  = byte_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  byte_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (load) begin
            byte_cnt <= '0;
        end else if (shift) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // Data path carries no reset: it is always loaded before it is observed.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= load_data;
        end else if (shift) begin
            shreg <= shreg << BYTE_W;
        end
    end

    assign byte_out = shreg[DATA_W-1 -: BYTE_W];
    assign last     = (byte_cnt == LAST_CNT);

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register bank on a start pulse and streams a sync byte followed by
// every register, MSB byte first, over a valid/ready byte interface.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int                NUM_REGS = 32,
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [BYTE_W-1:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    reg_dump_reader_if.master  bus,
    output logic               busy,
    output logic               done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q;
    dump_state_t       state_d;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              ser_load;
    logic              ser_shift;
    logic              ser_last;
    logic [BYTE_W-1:0] ser_byte;
    logic              idx_inc;
    logic              start_accept;

    word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (bus.rd_data),
        .shift     (ser_shift),
        .byte_out  (ser_byte),
        .last      (ser_last)
    );

    // Outputs decode straight from registered state, so tx_data/tx_valid stay
    // constant while a byte is stalled by tx_ready.
    always_comb begin
        state_d      = state_q;
        tx_valid     = 1'b0;
        tx_data      = '0;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;
        idx_inc      = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (bus.tx_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = ser_byte;
                if (bus.tx_ready) begin
                    ser_shift = 1'b1;
                    if (ser_last) begin
                        if (index_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_inc = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rd_addr mirrors index as a register so the bank sees a clean address.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q   <= '0;
            rd_addr_q <= '0;
        end else if (start_accept) begin
            index_q   <= '0;
            rd_addr_q <= '0;
        end else if (idx_inc) begin
            index_q   <= index_q + ADDR_W'(1);
            rd_addr_q <= index_q + ADDR_W'(1);
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: cycle-table checks on a 32-register
// instance plus whole-dump sequences on 32- and 4-register instances.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a;
    logic start_b;
    logic tx_ready;
    logic busy_a, done_a, busy_b, done_b;
    logic sel;

    reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
    reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

    assign ifa.rd_data  = 32'h1000_0000 + {27'd0, ifa.rd_addr};
    assign ifb.rd_data  = 32'h1000_0000 + {27'd0, ifb.rd_addr};
    assign ifa.tx_ready = tx_ready;
    assign ifb.tx_ready = tx_ready;

    reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .HDR_BYTE(8'hA5)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .start (start_a),
        .bus   (ifa),
        .busy  (busy_a),
        .done  (done_a)
    );

    reg_dump_reader #(.NUM_REGS(4), .ADDR_W(5), .DATA_W(32), .HDR_BYTE(8'hA5)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .start (start_b),
        .bus   (ifb),
        .busy  (busy_b),
        .done  (done_b)
    );

    logic       obs_valid, obs_busy, obs_done;
    logic [7:0] obs_data;
    assign obs_valid = sel ? ifb.tx_valid : ifa.tx_valid;
    assign obs_data  = sel ? ifb.tx_data  : ifa.tx_data;
    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_done  = sel ? done_b : done_a;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    // Full dump from IDLE; j counts cycles after the cycle start is presented.
    task automatic run_dump(input string tag, input bit rnd, input bit extra,
                            input bit hold, input int exp_done);
        logic [7:0] got[$];
        logic [7:0] exp_b[$];
        logic [31:0] w;
        int nregs, done_j, done_cnt, stab_err, busy_err, byte_err;
        bit pv, pr;
        logic [7:0] pd;
        nregs = sel ? 4 : 32;
        done_j = -1; done_cnt = 0; stab_err = 0; busy_err = 0; byte_err = 0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        exp_b.push_back(8'hA5);
        for (int i = 0; i < nregs; i++) begin
            w = 32'h1000_0000 + 32'(i);
            exp_b.push_back(w[31:24]);
            exp_b.push_back(w[23:16]);
            exp_b.push_back(w[15:8]);
            exp_b.push_back(w[7:0]);
        end
        @(negedge clk);
        drive_start(1'b1);
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int j = 1; j < 3000; j++) begin
            @(negedge clk);
            drive_start(hold || (extra && (j == 20 || j == 100)));
            if (pv && !pr && (obs_valid !== 1'b1 || obs_data !== pd)) stab_err++;
            if (done_j < 0 && obs_busy !== 1'b1) busy_err++;
            if (obs_done === 1'b1) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
            end
            if (done_j >= 0 && j == done_j + 1) begin
                check({tag, "_busy_after_done"}, 32'(obs_busy), 32'd0);
                check({tag, "_valid_after_done"}, 32'(obs_valid), 32'd0);
            end
            if (done_j >= 0 && j == done_j + 2) begin
                if (hold) begin
                    check({tag, "_retrigger_valid"}, 32'(obs_valid), 32'd1);
                    check({tag, "_retrigger_hdr"}, 32'(obs_data), 32'hA5);
                end else begin
                    check({tag, "_idle_valid"}, 32'(obs_valid), 32'd0);
                end
                break;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_j < 0 && obs_valid === 1'b1 && tx_ready) got.push_back(obs_data);
            pv = obs_valid; pr = tx_ready; pd = obs_data;
        end
        drive_start(1'b0);
        check({tag, "_done_seen"}, 32'(done_j >= 0), 32'd1);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        if (exp_done > 0) check({tag, "_done_cycle"}, 32'(done_j), 32'(exp_done));
        check({tag, "_stream_len"}, 32'(got.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
            if (got[i] !== exp_b[i]) begin
                if (byte_err == 0)
                    $display("note %s first byte difference at %0d: %0h vs %0h", tag, i, got[i], exp_b[i]);
                byte_err++;
            end
        end
        check({tag, "_stream_bytes"}, 32'(byte_err), 32'd0);
        check({tag, "_handshake_stable"}, 32'(stab_err), 32'd0);
        check({tag, "_busy_held"}, 32'(busy_err), 32'd0);
        pulse_reset();
    endtask

    typedef struct {
        logic       rst;
        logic       st;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_addr;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[19];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, done_seen;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_ready = 1'b1; sel = 1'b0;

        //          rst   st    rdy   valid data   addr busy  done
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 5'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 5'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 5'd1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 5'd1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; start_a = vecs[i].st; tx_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(ifa.tx_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_data", i),  32'(ifa.tx_data),  32'(vecs[i].e_data));
            check($sformatf("vec%0d_addr", i),  32'(ifa.rd_addr),  32'(vecs[i].e_addr));
            check($sformatf("vec%0d_busy", i),  32'(busy_a),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i),  32'(done_a),       32'(vecs[i].e_done));
        end
        start_a = 1'b0;

        run_dump("full", 1'b0, 1'b0, 1'b0, 194);
        run_dump("rand_ready", 1'b1, 1'b0, 1'b0, 0);
        run_dump("extra_start", 1'b0, 1'b1, 1'b0, 194);

        // Abort after the 50th accepted byte.
        @(negedge clk);
        start_a = 1'b1; tx_ready = 1'b1; cnt = 0; done_seen = 0;
        for (int j = 1; j < 400; j++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a === 1'b1) done_seen++;
            if (ifa.tx_valid === 1'b1) cnt++;
            if (cnt == 50) break;
        end
        check("abort_reached_50", 32'(cnt), 32'd50);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(ifa.tx_valid), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_addr", 32'(ifa.rd_addr), 32'd0);
        check("abort_data", 32'(ifa.tx_data), 32'd0);
        if (done_a === 1'b1) done_seen++;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (done_a === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_dump("restart", 1'b0, 1'b0, 1'b0, 194);

        run_dump("start_held", 1'b0, 1'b0, 1'b1, 194);

        sel = 1'b1;
        run_dump("regs4", 1'b0, 1'b0, 1'b0, 26);
        run_dump("regs4_rand", 1'b1, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
